// File: rtl/uart_host_command_master.sv
// Purpose: host-side UART command initiator; serialises one request into command bytes, collects response bytes.
// Latency: first tx byte the cycle after acceptance; response strobe one cycle after the last tx/rx byte.
// Backpressure: tx_data held until tx_valid&&tx_ready; request_ready low while a transaction is in flight.
// Optional: define HOST_RESPONSE_TIMEOUT_EN to bound each awaited response byte to TIMEOUT_CYCLES (status 3).
module uart_host_command_master #(
    parameter int DATA_WIDTH          = 8,
    parameter int REGISTER_FILE_DEPTH = 16,
    parameter int FUNCTION_WIDTH      = 4,
    parameter int TIMEOUT_CYCLES      = 100000
) (
    input  logic                                   reference_clk,
    input  logic                                   reset,
    input  logic                                   request_valid,
    output logic                                   request_ready,
    input  logic [1:0]                             request_kind,
    input  logic [$clog2(REGISTER_FILE_DEPTH)-1:0] request_address,
    input  logic [DATA_WIDTH-1:0]                  request_write_data,
    input  logic [DATA_WIDTH-1:0]                  request_operand_a,
    input  logic [DATA_WIDTH-1:0]                  request_operand_b,
    input  logic [FUNCTION_WIDTH-1:0]              request_function,
    output logic [DATA_WIDTH-1:0]                  tx_data,
    output logic                                   tx_valid,
    input  logic                                   tx_ready,
    input  logic [DATA_WIDTH-1:0]                  rx_data,
    input  logic                                   rx_valid,
    input  logic                                   rx_parity_error,
    input  logic                                   rx_frame_error,
    output logic                                   response_valid,
    output logic [2*DATA_WIDTH-1:0]                response_data,
    output logic [1:0]                             response_status
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_RESPONSE,
        S_DONE
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_seq [4];
    logic [1:0]            r_tx_idx;
    logic [1:0]            r_tx_last;
    logic [1:0]            r_rx_cnt;
    logic [1:0]            r_rx_expect;

    logic [DATA_WIDTH-1:0] w_seq [4];
    logic [1:0]            w_tx_last;
    logic [1:0]            w_rx_expect;

`ifdef HOST_RESPONSE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]         r_timeout;
`else
    logic                  w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT_CYCLES;
`endif

    // Build the command byte sequence and expected response length for the offered request.
    always_comb begin
        w_seq[0]    = '0;
        w_seq[1]    = '0;
        w_seq[2]    = '0;
        w_seq[3]    = '0;
        w_tx_last   = 2'd0;
        w_rx_expect = 2'd0;
        case (request_kind)
            2'd0: begin
                w_seq[0]    = DATA_WIDTH'(8'hAA);
                w_seq[1]    = DATA_WIDTH'(request_address);
                w_seq[2]    = request_write_data;
                w_tx_last   = 2'd2;
                w_rx_expect = 2'd0;
            end
            2'd1: begin
                w_seq[0]    = DATA_WIDTH'(8'hBB);
                w_seq[1]    = DATA_WIDTH'(request_address);
                w_tx_last   = 2'd1;
                w_rx_expect = 2'd1;
            end
            2'd2: begin
                w_seq[0]    = DATA_WIDTH'(8'hCC);
                w_seq[1]    = request_operand_a;
                w_seq[2]    = request_operand_b;
                w_seq[3]    = DATA_WIDTH'(request_function);
                w_tx_last   = 2'd3;
                w_rx_expect = 2'd2;
            end
            default: begin
                w_seq[0]    = DATA_WIDTH'(8'hDD);
                w_seq[1]    = DATA_WIDTH'(request_function);
                w_tx_last   = 2'd1;
                w_rx_expect = 2'd2;
            end
        endcase
    end

    // Transaction FSM: accept, send bytes, collect response, strobe completion; all outputs registered.
    always_ff @(posedge reference_clk) begin
        if (reset) begin
            r_state         <= S_IDLE;
            request_ready   <= 1'b1;
            tx_valid        <= 1'b0;
            tx_data         <= '0;
            response_valid  <= 1'b0;
            response_data   <= '0;
            response_status <= 2'd0;
            r_tx_idx        <= 2'd0;
            r_tx_last       <= 2'd0;
            r_rx_cnt        <= 2'd0;
            r_rx_expect     <= 2'd0;
            for (int i = 0; i < 4; i++) r_seq[i] <= '0;
`ifdef HOST_RESPONSE_TIMEOUT_EN
            r_timeout       <= '0;
`endif
        end else begin
            response_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (request_valid && request_ready) begin
                        r_seq           <= w_seq;
                        r_tx_last       <= w_tx_last;
                        r_rx_expect     <= w_rx_expect;
                        r_tx_idx        <= 2'd0;
                        r_rx_cnt        <= 2'd0;
                        response_data   <= '0;
                        response_status <= 2'd0;
                        request_ready   <= 1'b0;
                        tx_valid        <= 1'b1;
                        tx_data         <= w_seq[0];
                        r_state         <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (tx_valid && tx_ready) begin
                        if (r_tx_idx == r_tx_last) begin
                            tx_valid <= 1'b0;
                            tx_data  <= '0;
                            if (r_rx_expect == 2'd0) begin
                                response_valid <= 1'b1;
                                r_state        <= S_DONE;
                            end else begin
                                r_state <= S_WAIT_RESPONSE;
`ifdef HOST_RESPONSE_TIMEOUT_EN
                                r_timeout <= '0;
`endif
                            end
                        end else begin
                            r_tx_idx <= r_tx_idx + 2'd1;
                            tx_data  <= r_seq[r_tx_idx + 2'd1];
                        end
                    end
                end
                S_WAIT_RESPONSE: begin
                    if (rx_valid) begin
                        if (rx_parity_error) begin
                            response_status <= 2'd1;
                            response_valid  <= 1'b1;
                            r_state         <= S_DONE;
                        end else if (rx_frame_error) begin
                            response_status <= 2'd2;
                            response_valid  <= 1'b1;
                            r_state         <= S_DONE;
                        end else begin
                            if (r_rx_cnt[0]) response_data[2*DATA_WIDTH-1:DATA_WIDTH] <= rx_data;
                            else             response_data[DATA_WIDTH-1:0]            <= rx_data;
                            if (r_rx_cnt == r_rx_expect - 2'd1) begin
                                response_valid <= 1'b1;
                                r_state        <= S_DONE;
                            end else begin
                                r_rx_cnt <= r_rx_cnt + 2'd1;
                            end
`ifdef HOST_RESPONSE_TIMEOUT_EN
                            r_timeout <= '0;
`endif
                        end
                    end
`ifdef HOST_RESPONSE_TIMEOUT_EN
                    else if (r_timeout == TW'(TIMEOUT_CYCLES - 1)) begin
                        response_status <= 2'd3;
                        response_valid  <= 1'b1;
                        r_state         <= S_DONE;
                    end else begin
                        r_timeout <= r_timeout + 1'b1;
                    end
`endif
                end
                default: begin
                    request_ready <= 1'b1;
                    r_state       <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_host_command_master.sv
// Scoreboard bench for uart_host_command_master: stimulus pushes expected tx bytes and responses,
// a negedge monitor pops and compares on every tx handshake and response strobe.
module tb_uart_host_command_master;

    typedef struct {
        logic [15:0] data;
        logic [1:0]  status;
        int          delay;   // cycles from last tx handshake to response; 0 = unchecked
    } resp_t;

    logic        reference_clk = 1'b0;
    logic        reset;
    logic        request_valid;
    logic        request_ready;
    logic [1:0]  request_kind;
    logic [3:0]  request_address;
    logic [7:0]  request_write_data;
    logic [7:0]  request_operand_a;
    logic [7:0]  request_operand_b;
    logic [3:0]  request_function;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_parity_error;
    logic        rx_frame_error;
    logic        response_valid;
    logic [15:0] response_data;
    logic [1:0]  response_status;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_hs = 0;
    int resp_count = 0;
    int resp_expected = 0;

    logic [7:0] exp_tx[$];
    resp_t      exp_resp[$];
    logic [7:0] m_tx;
    resp_t      m_resp;

    int   tx_mode = 0;            // 0: always ready, 1: toggling, 2: manual
    logic tog = 1'b0;
    logic tx_ready_manual = 1'b0;
    logic prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always #5 reference_clk = ~reference_clk;
    always @(posedge reference_clk) tog <= ~tog;
    assign tx_ready = (tx_mode == 0) ? 1'b1 : (tx_mode == 1) ? tog : tx_ready_manual;

    uart_host_command_master #(
        .DATA_WIDTH(8),
        .REGISTER_FILE_DEPTH(16),
        .FUNCTION_WIDTH(4),
        .TIMEOUT_CYCLES(50)
    ) dut (
        .reference_clk(reference_clk),
        .reset(reset),
        .request_valid(request_valid),
        .request_ready(request_ready),
        .request_kind(request_kind),
        .request_address(request_address),
        .request_write_data(request_write_data),
        .request_operand_a(request_operand_a),
        .request_operand_b(request_operand_b),
        .request_function(request_function),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_parity_error(rx_parity_error),
        .rx_frame_error(rx_frame_error),
        .response_valid(response_valid),
        .response_data(response_data),
        .response_status(response_status)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Monitor: compares tx handshakes and response strobes against the scoreboard queues.
    always @(negedge reference_clk) begin
        cyc++;
        if (prev_stall && tx_valid && !reset) check("tx_stable", {24'd0, tx_data}, {24'd0, prev_data});
        prev_stall = tx_valid && !tx_ready && !reset;
        prev_data  = tx_data;
        if (tx_valid && tx_ready && !reset) begin
            if (exp_tx.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tx_unexpected: got %0h expected none", tx_data);
            end else begin
                m_tx = exp_tx.pop_front();
                check("tx_byte", {24'd0, tx_data}, {24'd0, m_tx});
            end
            last_hs = cyc;
        end
        if (response_valid === 1'b1) begin
            resp_count++;
            if (exp_resp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL resp_unexpected: got data %0h status %0d expected none", response_data, response_status);
            end else begin
                m_resp = exp_resp.pop_front();
                check("resp_data", {16'd0, response_data}, {16'd0, m_resp.data});
                check("resp_status", {30'd0, response_status}, {30'd0, m_resp.status});
                if (m_resp.delay != 0) check("resp_latency", cyc - last_hs, m_resp.delay);
            end
        end
    end

    task automatic tick();
        @(posedge reference_clk);
        #1;
    endtask

    task automatic push_resp(input logic [15:0] d, input logic [1:0] s, input int dly);
        resp_t r;
        r.data = d;
        r.status = s;
        r.delay = dly;
        exp_resp.push_back(r);
        resp_expected++;
    endtask

    task automatic issue(input logic [1:0] k, input logic [3:0] addr, input logic [7:0] wd,
                         input logic [7:0] a, input logic [7:0] b, input logic [3:0] fn);
        for (int i = 0; i < 100 && request_ready !== 1'b1; i++) tick();
        check("ready_wait", {31'd0, request_ready}, 32'd1);
        request_kind       = k;
        request_address    = addr;
        request_write_data = wd;
        request_operand_a  = a;
        request_operand_b  = b;
        request_function   = fn;
        request_valid      = 1'b1;
        tick();
        request_valid      = 1'b0;
        check("ready_low_after_accept", {31'd0, request_ready}, 32'd0);
        check("tx_valid_after_accept", {31'd0, tx_valid}, 32'd1);
    endtask

    task automatic wait_tx_idle();
        for (int i = 0; i < 100 && tx_valid !== 1'b0; i++) tick();
        check("tx_idle_wait", {31'd0, tx_valid}, 32'd0);
    endtask

    task automatic send_rx(input logic [7:0] d, input logic pe, input logic fe);
        rx_data         = d;
        rx_parity_error = pe;
        rx_frame_error  = fe;
        rx_valid        = 1'b1;
        tick();
        rx_valid        = 1'b0;
        rx_parity_error = 1'b0;
        rx_frame_error  = 1'b0;
    endtask

    task automatic wait_resp(input int budget);
        for (int i = 0; i < budget && resp_count < resp_expected; i++) tick();
        check("resp_arrived", resp_count, resp_expected);
        tick();
    endtask

    initial begin
        reset = 1'b1;
        request_valid = 1'b0;
        request_kind = 2'd0;
        request_address = 4'd0;
        request_write_data = 8'd0;
        request_operand_a = 8'd0;
        request_operand_b = 8'd0;
        request_function = 4'd0;
        rx_data = 8'd0;
        rx_valid = 1'b0;
        rx_parity_error = 1'b0;
        rx_frame_error = 1'b0;
        repeat (3) tick();
        check("rst_ready", {31'd0, request_ready}, 32'd1);
        check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'd0);
        check("rst_resp_valid", {31'd0, response_valid}, 32'd0);
        check("rst_resp_data", {16'd0, response_data}, 32'd0);
        check("rst_resp_status", {30'd0, response_status}, 32'd0);
        reset = 1'b0;
        tick();

        // register write: no response bytes, strobe one cycle after the last handshake
        exp_tx.push_back(8'hAA); exp_tx.push_back(8'h05); exp_tx.push_back(8'h3C);
        push_resp(16'h0000, 2'd0, 1);
        issue(2'd0, 4'd5, 8'h3C, 8'h00, 8'h00, 4'd0);
        wait_resp(50);

        // register read
        exp_tx.push_back(8'hBB); exp_tx.push_back(8'h05);
        push_resp(16'h003C, 2'd0, 0);
        issue(2'd1, 4'd5, 8'h00, 8'h00, 8'h00, 4'd0);
        wait_tx_idle();
        send_rx(8'h3C, 1'b0, 1'b0);
        wait_resp(50);
        // rx strobe while idle is ignored and the last response holds
        tick();
        send_rx(8'h77, 1'b0, 1'b0);
        tick();
        check("idle_rx_data_hold", {16'd0, response_data}, 32'h003C);
        check("idle_rx_ready", {31'd0, request_ready}, 32'd1);
        check("idle_rx_no_resp", resp_count, resp_expected);

        // ALU with operands, transmitter stalling every other cycle
        tx_mode = 1;
        exp_tx.push_back(8'hCC); exp_tx.push_back(8'h0A); exp_tx.push_back(8'h14); exp_tx.push_back(8'h00);
        push_resp(16'h001E, 2'd0, 0);
        issue(2'd2, 4'd0, 8'h00, 8'h0A, 8'h14, 4'd0);
        wait_tx_idle();
        tx_mode = 0;
        send_rx(8'h1E, 1'b0, 1'b0);
        tick();
        send_rx(8'h00, 1'b0, 1'b0);
        wait_resp(50);

        // ALU without operands, parity error aborts
        exp_tx.push_back(8'hDD); exp_tx.push_back(8'h02);
        push_resp(16'h0000, 2'd1, 0);
        issue(2'd3, 4'd0, 8'h00, 8'h00, 8'h00, 4'd2);
        wait_tx_idle();
        send_rx(8'hC8, 1'b1, 1'b0);
        wait_resp(50);
        send_rx(8'h55, 1'b1, 1'b1);
        tick();
        check("idle_err_no_resp", resp_count, resp_expected);
        check("idle_err_status_hold", {30'd0, response_status}, 32'd1);

        // frame error alone -> status 2
        exp_tx.push_back(8'hBB); exp_tx.push_back(8'h07);
        push_resp(16'h0000, 2'd2, 0);
        issue(2'd1, 4'd7, 8'h00, 8'h00, 8'h00, 4'd0);
        wait_tx_idle();
        send_rx(8'h12, 1'b0, 1'b1);
        wait_resp(50);

        // both errors -> parity wins
        exp_tx.push_back(8'hBB); exp_tx.push_back(8'h08);
        push_resp(16'h0000, 2'd1, 0);
        issue(2'd1, 4'd8, 8'h00, 8'h00, 8'h00, 4'd0);
        wait_tx_idle();
        send_rx(8'h34, 1'b1, 1'b1);
        wait_resp(50);

        // ALU: first byte clean, second errored -> first byte kept, errored byte dropped
        exp_tx.push_back(8'hCC); exp_tx.push_back(8'h01); exp_tx.push_back(8'h02); exp_tx.push_back(8'h03);
        push_resp(16'h0011, 2'd2, 0);
        issue(2'd2, 4'd0, 8'h00, 8'h01, 8'h02, 4'd3);
        wait_tx_idle();
        send_rx(8'h11, 1'b0, 1'b0);
        tick();
        send_rx(8'h22, 1'b0, 1'b1);
        wait_resp(50);

        // read with no response bytes
        exp_tx.push_back(8'hBB); exp_tx.push_back(8'h03);
`ifdef HOST_RESPONSE_TIMEOUT_EN
        push_resp(16'h0000, 2'd3, 51);
        issue(2'd1, 4'd3, 8'h00, 8'h00, 8'h00, 4'd0);
        wait_resp(300);
`else
        issue(2'd1, 4'd3, 8'h00, 8'h00, 8'h00, 4'd0);
        repeat (10000) tick();
        check("no_timeout_resp", resp_count, resp_expected);
        check("no_timeout_busy", {31'd0, request_ready}, 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
`endif

        // reset while the second byte of an ALU request is pending
        tx_mode = 2;
        tx_ready_manual = 1'b0;
        exp_tx.push_back(8'hCC);
        issue(2'd2, 4'd0, 8'h00, 8'h55, 8'h66, 4'd1);
        tx_ready_manual = 1'b1;
        tick();
        tx_ready_manual = 1'b0;
        check("second_byte_pending", {24'd0, tx_data}, 32'h55);
        reset = 1'b1;
        tick();
        check("mid_rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("mid_rst_ready", {31'd0, request_ready}, 32'd1);
        check("mid_rst_resp_valid", {31'd0, response_valid}, 32'd0);
        reset = 1'b0;
        tick();
        tx_mode = 0;
        exp_tx.push_back(8'hBB); exp_tx.push_back(8'h09);
        push_resp(16'h00A5, 2'd0, 0);
        issue(2'd1, 4'd9, 8'h00, 8'h00, 8'h00, 4'd0);
        wait_tx_idle();
        send_rx(8'hA5, 1'b0, 1'b0);
        wait_resp(50);

        repeat (3) tick();
        check("tx_queue_drained", exp_tx.size(), 0);
        check("resp_queue_drained", exp_resp.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
